// File: rtl/neo_pkg.sv
// Shared types for the NEO spike chain: sample/timestamp widths, the event record
// and the packer FSM states, plus the saturating magnitude helper.
package neo_pkg;

    localparam int TS_W  = 16;
    localparam int AMP_W = 16;

    typedef struct packed {
        logic [TS_W-1:0]  ts;
        logic [AMP_W-1:0] amp;
    } spike_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_REFRACT
    } pk_state_e;

    // Two's-complement magnitude; the most negative code has no positive twin, so clip it.
    function automatic logic [AMP_W-1:0] abs_sat(input logic [AMP_W-1:0] x);
        logic [AMP_W-1:0] most_neg;
        most_neg = {1'b1, {(AMP_W-1){1'b0}}};
        if (x == most_neg) return ~most_neg;
        if (x[AMP_W-1])    return ~x + AMP_W'(1);
        return x;
    endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO; the head entry is presented
// combinationally whenever the FIFO is non-empty.
module spike_evt_fifo
    import neo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  spike_evt_t             wdata_i,
    input  logic                   pop_i,
    output spike_evt_t             rdata_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    spike_evt_t  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (level_o == (AW+1)'(DEPTH));

    // A slot vacated by a same-cycle pop lets a push through even when full.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    assign rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spike_event_packer.sv
// Converts the level spike flag into timestamped peak-amplitude events with a
// refractory holdoff, queued in an FWFT FIFO behind a valid/ready handshake.
module spike_event_packer
    import neo_pkg::*;
#(
    parameter int PEAK_WIN = 4,
    parameter int REFRACT  = 16,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic                   spike_in,
    input  logic [AMP_W-1:0]       data_in,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [TS_W-1:0]        evt_ts,
    output logic [AMP_W-1:0]       evt_amp,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [7:0]             drop_cnt
);

    localparam int WIN_W = (PEAK_WIN < 2) ? 1 : $clog2(PEAK_WIN + 1);
    localparam int REF_W = (REFRACT < 2) ? 1 : $clog2(REFRACT + 1);
    localparam pk_state_e POST_PUSH = (REFRACT == 0) ? ST_IDLE : ST_REFRACT;

    pk_state_e        state_q, state_d;
    logic [TS_W-1:0]  ts_q, ts_cur_q, ts_cur_d;
    logic [AMP_W-1:0] peak_q, peak_d, mag, peak_max;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             spike_prev_q, edge_det;
    logic             overflow_q;
    logic [7:0]       drop_cnt_q;
    logic             push, pop, full, empty;
    spike_evt_t       push_evt, head;

    assign mag      = abs_sat(data_in);
    assign edge_det = spike_in & ~spike_prev_q;
    assign peak_max = (mag > peak_q) ? mag : peak_q;
    assign pop      = evt_valid & evt_ready;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d   = state_q;
        ts_cur_d  = ts_cur_q;
        peak_d    = peak_q;
        win_cnt_d = win_cnt_q;
        ref_cnt_d = ref_cnt_q;
        push      = 1'b0;
        push_evt  = '{ts: ts_cur_q, amp: peak_max};
        if (sample_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (edge_det) begin
                        ts_cur_d  = ts_q;
                        peak_d    = mag;
                        win_cnt_d = WIN_W'(1);
                        if (PEAK_WIN <= 1) begin
                            push      = 1'b1;
                            push_evt  = '{ts: ts_q, amp: mag};
                            state_d   = POST_PUSH;
                            ref_cnt_d = '0;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    peak_d    = peak_max;
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                    if (win_cnt_q == WIN_W'(PEAK_WIN - 1)) begin
                        push      = 1'b1;
                        state_d   = POST_PUSH;
                        ref_cnt_d = '0;
                    end
                end
                ST_REFRACT: begin
                    ref_cnt_d = ref_cnt_q + REF_W'(1);
                    if (ref_cnt_q == REF_W'(REFRACT - 1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            ts_cur_q     <= '0;
            peak_q       <= '0;
            win_cnt_q    <= '0;
            ref_cnt_q    <= '0;
            spike_prev_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            if (sample_en) begin
                ts_q         <= ts_q + TS_W'(1);
                spike_prev_q <= spike_in;
            end
            state_q   <= state_d;
            ts_cur_q  <= ts_cur_d;
            peak_q    <= peak_d;
            win_cnt_q <= win_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            // The FIFO refuses a push only when full with no pop in the same cycle.
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    spike_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (push_evt),
        .pop_i   (pop),
        .rdata_o (head),
        .empty_o (empty),
        .full_o  (full),
        .level_o (fifo_level)
    );

    assign evt_valid = ~empty;
    assign evt_ts    = head.ts;
    assign evt_amp   = head.amp;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spike_event_packer.sv
// Bench for spike_event_packer: magnitude vector table, directed multi-cycle
// sequences, and a randomized run against an event-level reference model.
module tb_spike_event_packer;
    import neo_pkg::*;

    localparam int PW = 4;
    localparam int RF = 16;
    localparam int DP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en, spike_in, evt_ready;
    logic [15:0] data_in;
    logic        evt_valid;
    logic [15:0] evt_ts, evt_amp;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    spike_event_packer #(.PEAK_WIN(PW), .REFRACT(RF), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .spike_in   (spike_in),
        .data_in    (data_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_ts     (evt_ts),
        .evt_amp    (evt_amp),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Event-level reference: works on sample indices, not on FSM state.
    spike_evt_t  m_q[$];
    int          m_k, m_start, m_elig, m_drop;
    bit          m_prev, m_pend, m_ovf;
    logic [15:0] m_peak;

    function automatic logic [15:0] ref_mag(input logic [15:0] d);
        int v;
        v = $signed(d);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v[15:0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_k = 0; m_start = 0; m_elig = 0; m_drop = 0;
        m_prev = 0; m_pend = 0; m_ovf = 0; m_peak = '0;
    endtask

    task automatic model_step(input bit en, input bit spk, input logic [15:0] d, input bit rdy);
        bit pop, push;
        spike_evt_t e;
        pop  = (m_q.size() > 0) && rdy;
        push = 0;
        e    = '0;
        if (en) begin
            if (!m_pend && m_k >= m_elig && spk && !m_prev) begin
                m_pend = 1; m_start = m_k; m_peak = '0;
            end
            if (m_pend) begin
                if (ref_mag(d) > m_peak) m_peak = ref_mag(d);
                if (m_k == m_start + PW - 1) begin
                    push = 1;
                    e.ts = m_start[15:0];
                    e.amp = m_peak;
                    m_pend = 0;
                    m_elig = m_k + 1 + RF;
                end
            end
            m_prev = spk;
            m_k++;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DP) m_q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
    endtask

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic drive(input bit en, input bit spk, input logic [15:0] d, input bit rdy);
        sample_en = en; spike_in = spk; data_in = d; evt_ready = rdy;
        if (!rst) model_step(en, spk, d, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_en = 0; spike_in = 0; data_in = '0; evt_ready = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic compare_model();
        check("rnd_valid", evt_valid, m_q.size() > 0);
        check("rnd_level", fifo_level, m_q.size());
        check("rnd_overflow", overflow, m_ovf);
        check("rnd_drop_cnt", drop_cnt, m_drop);
        if (m_q.size() > 0) begin
            check("rnd_ts", evt_ts, m_q[0].ts);
            check("rnd_amp", evt_amp, m_q[0].amp);
        end
    endtask

    typedef struct {
        int          trig;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] exp_amp;
    } amp_vec_t;

    amp_vec_t vec [7];

    initial begin
        bit seen;
        vec[0] = '{2, 16'h8000, 16'h0000, 16'd32767};
        vec[1] = '{3, 16'h7FFF, 16'h0000, 16'd32767};
        vec[2] = '{1, 16'hFFFF, 16'h0000, 16'd1};
        vec[3] = '{4, 16'h0000, 16'h0000, 16'd0};
        vec[4] = '{2, 16'd100,  16'(-200), 16'd200};
        vec[5] = '{5, 16'(-5),  16'd3,    16'd5};
        vec[6] = '{2, 16'h8001, 16'h8000, 16'd32767};

        do_reset();
        check("rst_valid", evt_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_ts", evt_ts, 0);
        check("rst_amp", evt_amp, 0);

        // Magnitude table: trigger sample d0, three following samples d1.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            repeat (vec[i].trig) drive(1, 0, 16'h0, 0);
            drive(1, 1, vec[i].d0, 0);
            repeat (PW - 1) drive(1, 0, vec[i].d1, 0);
            check("vec_valid", evt_valid, 1);
            check("vec_ts", evt_ts, vec[i].trig);
            check("vec_amp", evt_amp, vec[i].exp_amp);
        end

        // Basic capture, latency and pop.
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(1, c >= 10 && c <= 12,
                  (c == 10) ? 16'(-5) : (c == 11) ? 16'd300 :
                  (c == 12) ? 16'(-900) : (c == 13) ? 16'd20 : 16'd0, 0);
            if (c == 12) check("t1_valid_early", evt_valid, 0);
        end
        check("t1_valid", evt_valid, 1);
        check("t1_ts", evt_ts, 10);
        check("t1_amp", evt_amp, 900);
        check("t1_level", fifo_level, 1);
        drive(1, 0, 16'd0, 1);
        check("t1_popped_valid", evt_valid, 0);
        check("t1_popped_level", fifo_level, 0);

        // Edge inside refractory ignored; later edge accepted.
        seen = 0;
        for (int c = 15; c <= 38; c++) begin
            drive(1, c == 20 || c == 35, (c == 35) ? 16'd77 : 16'd0, 1);
            if (c < 38 && evt_valid) seen = 1;
        end
        check("t2_no_refract_evt", seen, 0);
        check("t2_valid", evt_valid, 1);
        check("t2_ts", evt_ts, 35);
        check("t2_amp", evt_amp, 77);

        // Overflow: nine events into an eight-deep FIFO with no reader.
        do_reset();
        for (int c = 0; c <= 209; c++)
            drive(1, c >= 5 && (c - 5) % 25 == 0,
                  (c >= 5 && (c - 5) % 25 == 0) ? 16'((c - 5) / 25 + 1) : 16'd0, 0);
        check("t3_level", fifo_level, 8);
        check("t3_overflow", overflow, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_head_ts", evt_ts, 5);
        for (int k = 0; k < 8; k++) begin
            check("t3_drain_ts", evt_ts, 5 + 25 * k);
            check("t3_drain_amp", evt_amp, k + 1);
            drive(1, 0, 16'd0, 1);
        end
        check("t3_empty", fifo_level, 0);
        check("t3_ovf_sticky", overflow, 1);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        for (int c = 0; c <= 208; c++)
            drive(1, c >= 5 && (c - 5) % 25 == 0, 16'd1, c == 208);
        check("t4_level", fifo_level, 8);
        check("t4_overflow", overflow, 0);
        check("t4_drop_cnt", drop_cnt, 0);
        check("t4_head_ts", evt_ts, 30);

        // Reset mid-capture, then sample_en gaps stretch the window.
        do_reset();
        for (int c = 0; c <= 31; c++)
            drive(1, c == 2 || c == 30, (c == 2 || c == 30) ? 16'd50 : 16'd0, 0);
        check("t6_pre_valid", evt_valid, 1);
        rst = 1'b1;
        spike_in = 0;
        model_reset();
        #1;
        check("t6_rst_valid", evt_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_ts", evt_ts, 0);
        check("t6_rst_amp", evt_amp, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (s == 5) check("t6_no_early", evt_valid, 0);
            drive(1, s == 2, (s == 2) ? 16'd10 : (s == 3) ? 16'(-40) : (s == 4) ? 16'd7 : 16'd0, 0);
            if (s < 5) drive(0, s == 2, 16'h8000, 0);
        end
        check("t6_valid", evt_valid, 1);
        check("t6_ts", evt_ts, 2);
        check("t6_amp", evt_amp, 40);
        check("t6_level", fifo_level, 1);

        // Randomized run against the reference model, with long reader stalls.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom),
                  ((i / 400) % 2 == 1) ? ($urandom_range(0, 1) == 1) : 1'b0);
            compare_model();
        end

        // Timestamp wrap: trigger on the sample after 65535.
        do_reset();
        repeat (65536) drive(1, 0, 16'd0, 0);
        drive(1, 1, 16'(-100), 0);
        repeat (PW - 1) drive(1, 0, 16'd0, 0);
        check("t5_valid", evt_valid, 1);
        check("t5_wrap_ts", evt_ts, 0);
        check("t5_amp", evt_amp, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
